mips_multicycle_ctrl: RTL
=========================

Name: mips_multicycle_ctrl

Overview:
- Control unit for the multicycle MIPS datapath. It succeeds the single-cycle main decoder plus ALU decoder pair.
- Moore FSM sequences fetch, decode, execute, memory and writeback over several cycles, driving the shared-memory datapath.
- ALU-control decode is kept, widened by parameter.
- Adds a memory-ready handshake, optional ADDI/J support, and an illegal-opcode flag.

Parameters:
- ALUCTRL_W, 3: alucontrol width; upper bits beyond 3 are driven zero.
- MEM_WAIT, 1: 1 = honour mem_ready; 0 = mem_ready internally tied to 1.
- EN_ADDI, 1: 1 = decode opcode 001000 (addi); 0 = treat it as illegal.
- EN_JUMP, 1: 1 = decode opcode 000010 (j); 0 = treat it as illegal.

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  synchronous active-low reset
- opcode  in  6  instr[31:26], taken from the instruction register
- funct  in  6  instr[5:0]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- memwrite  out  1  memory write strobe
- irwrite  out  1  instruction register load
- pcen  out  1  PC load = pcwrite | (branch & zero)
- regwrite  out  1  register file write
- regdst  out  1  1 = rd, 0 = rt
- memtoreg  out  1  1 = Data register, 0 = ALUOut
- alusrca  out  1  0 = PC, 1 = A
- alusrcb  out  2  00 = B, 01 = const 4, 10 = SignImm, 11 = SignImm<<2
- pcsrc  out  2  00 = ALUResult, 01 = ALUOut, 10 = jump target
- alucontrol  out  ALUCTRL_W  ALU operation
- illegal  out  1  one-cycle pulse on an undecodable opcode
- instr_done  out  1  one-cycle pulse in the final state of each instruction

Behaviour:
- Reset: when rst_n=0 at a rising edge, state <= FETCH and illegal/instr_done flags are cleared. Reset asserted mid-instruction aborts that instruction; no write strobe fires in the reset cycle.
- While rst_n=0, all write strobes (memwrite, irwrite, pcen, regwrite) are forced 0. All other outputs are 0 except alusrcb=01 and alucontrol=010.
- Outputs are combinational from state (plus mem_ready/zero where noted). Latency: 3-5 cycles per instruction plus memory wait cycles.
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP.
- FETCH:
  - iord=0, alusrca=0, alusrcb=01, add, pcsrc=00.
  - irwrite = pcwrite = mem_ready.
  - Advance to DECODE only when mem_ready=1; otherwise hold.
- DECODE: alusrca=0, alusrcb=11, add. Next state by opcode:
  - 100011 / 101011 -> MEMADR
  - 000000 -> EXEC
  - 000100 -> BRANCH
  - 001000 -> ADDIEX (if EN_ADDI)
  - 000010 -> JUMP (if EN_JUMP)
  - anything else -> FETCH, with illegal=1 for this cycle
- MEMADR: alusrca=1, alusrcb=10, add. Next is MEMRD for lw, MEMWR for sw.
- MEMRD: iord=1. Hold until mem_ready, then go to MEMWB.
- MEMWB: regwrite=1, regdst=0, memtoreg=1, instr_done=1. Next is FETCH.
- MEMWR: iord=1, memwrite=1 (held for every wait cycle). On mem_ready, instr_done=1 and next is FETCH.
- EXEC: alusrca=1, alusrcb=00, alucontrol from funct:
  - 100000 -> 010
  - 100010 -> 110
  - 100100 -> 000
  - 100101 -> 001
  - 101010 -> 111
  - other funct: 010 and illegal=1, but the FSM still proceeds.
  - Next is ALUWB.
- ALUWB: regwrite=1, regdst=1, memtoreg=0, instr_done=1. Next is FETCH.
- BRANCH: alusrca=1, alusrcb=00, sub (110), pcsrc=01, branch=1. pcen=zero, instr_done=1. Next is FETCH.
- ADDIEX: alusrca=1, alusrcb=10, add. Next is ADDIWB.
- ADDIWB: regwrite=1, regdst=0, memtoreg=0, instr_done=1. Next is FETCH.
- JUMP: pcsrc=10, pcen=1, instr_done=1. Next is FETCH.
- MEM_WAIT=0: every memory state completes in exactly one cycle.
- mem_ready asserted outside a memory state is ignored.
- Unused state encodings recover to FETCH on the next edge with no strobes asserted.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - state enum;
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J);
  - funct constants;
  - ALU control codes (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT);
  - aluop 2-bit codes.
- One sub-module, mips_alu_dec (aluop, funct -> alucontrol, illegal_funct), combinational. The FSM owns all sequencing.

Test Plan:
- rst_n=0 for 2 cycles, then 1 with mem_ready=1 -> regwrite=memwrite=pcen=0 during reset; FETCH outputs alusrcb=01, irwrite=1, pcen=1 in the first cycle after release.
- lw (opcode 100011), mem_ready stuck 0 for 3 cycles in MEMRD -> state holds, regwrite=0; MEMWB regwrite=1 and memtoreg=1 one cycle after mem_ready=1; instr_done pulses once.
- R-type funct 101010 -> alucontrol=111 in EXEC; regwrite=1 and regdst=1 in ALUWB; total 4 cycles with MEM_WAIT=0.
- beq with zero=1, then with zero=0 -> pcen=1 with pcsrc=01, then pcen=0; FETCH follows in both cases.
- opcode 111111, and 001000 with EN_ADDI=0 -> illegal=1 for one cycle in DECODE; return to FETCH; no write strobes asserted.
- sw with rst_n dropped while in MEMWR -> memwrite=0 in the reset cycle; state=FETCH after the edge.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control unit: FSM state
// encoding, opcode/funct field values, ALU control codes, the aluop
// selector between the FSM and the ALU decoder, and datapath mux codes.
package mips_ctrl_pkg;

  // Twelve states in a 4-bit register. Encodings 12..15 are unused and
  // fall back to FETCH through the default branch of the next-state logic.
  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10,
    JUMP   = 4'd11
  } state_t;

  // instr[31:26]
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // instr[5:0] for R-type
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALU operation codes
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // What the FSM asks the ALU decoder for in the current state.
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  // ALU source B select
  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMX4 = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_alu_dec.sv
// ALU control decoder (combinational).
//   aluop         in  FSM request: add, sub, or decode from funct
//   funct         in  instr[5:0]
//   alucontrol    out 3-bit ALU operation
//   illegal_funct out high when aluop asks for funct decode and funct is unknown
module mips_alu_dec
  import mips_ctrl_pkg::*;
(
  input  aluop_t      aluop,
  input  logic [5:0]  funct,
  output logic [2:0]  alucontrol,
  output logic        illegal_funct
);

  // NOTE: every output gets a value before the case statement so that no
  // path leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    alucontrol    = ALU_ADD;
    illegal_funct = 1'b0;
    case (aluop)
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alucontrol = ALU_ADD;
          FN_SUB:  alucontrol = ALU_SUB;
          FN_AND:  alucontrol = ALU_AND;
          FN_OR:   alucontrol = ALU_OR;
          FN_SLT:  alucontrol = ALU_SLT;
          default: illegal_funct = 1'b1;   // unknown funct still adds
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control unit: Moore FSM sequencing fetch, decode,
// execute, memory and writeback over a shared-memory datapath.
//   clk, rst_n   clock, synchronous active-low reset
//   opcode/funct instruction fields from the instruction register
//   zero         ALU zero flag (qualifies branch PC load)
//   mem_ready    memory finishes the current access this cycle
//   iord, memwrite, irwrite, pcen, regwrite, regdst, memtoreg,
//   alusrca, alusrcb, pcsrc, alucontrol   datapath controls
//   illegal      pulse on unknown opcode (DECODE) or funct (EXEC)
//   instr_done   pulse in the final state of each instruction
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int ALUCTRL_W = 3,
  parameter bit MEM_WAIT  = 1'b1,
  parameter bit EN_ADDI   = 1'b1,
  parameter bit EN_JUMP   = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [5:0]           opcode,
  input  logic [5:0]           funct,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 iord,
  output logic                 memwrite,
  output logic                 irwrite,
  output logic                 pcen,
  output logic                 regwrite,
  output logic                 regdst,
  output logic                 memtoreg,
  output logic                 alusrca,
  output logic [1:0]           alusrcb,
  output logic [1:0]           pcsrc,
  output logic [ALUCTRL_W-1:0] alucontrol,
  output logic                 illegal,
  output logic                 instr_done
);

  state_t     state, next;
  aluop_t     aluop;
  logic       mem_rdy;
  logic       pcwrite, branch, illegal_op, illegal_funct;
  logic [2:0] alu3;

  assign mem_rdy = MEM_WAIT ? mem_ready : 1'b1;

  // NOTE: state is updated with non-blocking assignment so every reader of
  // 'state' in this time step sees the pre-edge value.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= FETCH;
    else        state <= next;
  end

  always_comb begin
    next       = FETCH;
    iord       = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    regwrite   = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = SRCB_REG;
    pcsrc      = PCSRC_ALU;
    aluop      = ALUOP_ADD;
    illegal_op = 1'b0;
    instr_done = 1'b0;

    case (state)
      FETCH: begin
        alusrcb = SRCB_FOUR;
        irwrite = mem_rdy;
        pcwrite = mem_rdy;
        next    = mem_rdy ? DECODE : FETCH;
      end
      DECODE: begin
        alusrcb = SRCB_IMMX4;   // precompute branch target into ALUOut
        case (opcode)
          OP_LW, OP_SW: next = MEMADR;
          OP_RTYPE:     next = EXEC;
          OP_BEQ:       next = BRANCH;
          OP_ADDI: begin
            if (EN_ADDI) next = ADDIEX;
            else         illegal_op = 1'b1;
          end
          OP_J: begin
            if (EN_JUMP) next = JUMP;
            else         illegal_op = 1'b1;
          end
          default:      illegal_op = 1'b1;
        endcase
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
        next    = (opcode == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        iord = 1'b1;
        next = mem_rdy ? MEMWB : MEMRD;
      end
      MEMWB: begin
        regwrite   = 1'b1;
        memtoreg   = 1'b1;
        instr_done = 1'b1;
      end
      MEMWR: begin
        iord       = 1'b1;
        memwrite   = 1'b1;      // held through wait cycles
        instr_done = mem_rdy;
        next       = mem_rdy ? FETCH : MEMWR;
      end
      EXEC: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
        next    = ALUWB;
      end
      ALUWB: begin
        regwrite   = 1'b1;
        regdst     = 1'b1;
        instr_done = 1'b1;
      end
      BRANCH: begin
        alusrca    = 1'b1;
        aluop      = ALUOP_SUB;
        pcsrc      = PCSRC_ALUOUT;
        branch     = 1'b1;
        instr_done = 1'b1;
      end
      ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
        next    = ADDIWB;
      end
      ADDIWB: begin
        regwrite   = 1'b1;
        instr_done = 1'b1;
      end
      JUMP: begin
        pcsrc      = PCSRC_JUMP;
        pcwrite    = 1'b1;
        instr_done = 1'b1;
      end
      default: next = FETCH;
    endcase

    // Reset overrides everything: no strobes, fetch-style ALU setup.
    if (!rst_n) begin
      iord       = 1'b0;
      memwrite   = 1'b0;
      irwrite    = 1'b0;
      pcwrite    = 1'b0;
      branch     = 1'b0;
      regwrite   = 1'b0;
      regdst     = 1'b0;
      memtoreg   = 1'b0;
      alusrca    = 1'b0;
      alusrcb    = SRCB_FOUR;
      pcsrc      = PCSRC_ALU;
      aluop      = ALUOP_ADD;
      illegal_op = 1'b0;
      instr_done = 1'b0;
    end
  end

  mips_alu_dec u_alu_dec (
    .aluop         (aluop),
    .funct         (funct),
    .alucontrol    (alu3),
    .illegal_funct (illegal_funct)
  );

  assign pcen       = pcwrite | (branch & zero);
  assign illegal    = illegal_op | illegal_funct;
  assign alucontrol = ALUCTRL_W'(alu3);

endmodule
